// File: rtl/apb_master_gen_if.sv
// Request/response handshake and APB bus bundle for apb_master_gen.
// The master modport is the bus master's view; slave is the environment's view.
interface apb_master_gen_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [STRB_WIDTH-1:0] req_strb;

    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  rsp_timeout;

    logic                  P_sel;
    logic                  P_enable;
    logic                  P_write;
    logic [ADDR_WIDTH-1:0] P_addr;
    logic [DATA_WIDTH-1:0] P_wdata;
    logic [STRB_WIDTH-1:0] P_strb;
    logic [DATA_WIDTH-1:0] P_rdata;
    logic                  P_ready;
    logic                  P_slverr;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, req_strb,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output P_sel, P_enable, P_write, P_addr, P_wdata, P_strb,
        input  P_rdata, P_ready, P_slverr
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, req_strb,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  P_sel, P_enable, P_write, P_addr, P_wdata, P_strb,
        output P_rdata, P_ready, P_slverr
    );
endinterface

// File: rtl/apb_master_gen.sv
// Parametrised APB4-style master: one valid/ready request becomes one
// IDLE->SETUP->ACCESS transfer, with slave-error/timeout reporting.
module apb_master_gen #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic             P_clk,
    input  logic             P_reset_n,
    apb_master_gen_if.master bus,
    output logic [7:0]       err_count
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int WAIT_WIDTH = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_WIDTH-1:0] WAIT_LAST =
        WAIT_WIDTH'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t                state_q, state_d;
    logic                  p_sel_q, p_sel_d;
    logic                  p_enable_q, p_enable_d;
    logic                  p_write_q, p_write_d;
    logic [ADDR_WIDTH-1:0] p_addr_q, p_addr_d;
    logic [DATA_WIDTH-1:0] p_wdata_q, p_wdata_d;
    logic [STRB_WIDTH-1:0] p_strb_q, p_strb_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  rsp_timeout_q, rsp_timeout_d;
    logic [7:0]            err_count_q, err_count_d;
    logic [WAIT_WIDTH-1:0] wait_cnt_q, wait_cnt_d;

    // Response fields are only meaningful for the single cycle they pulse,
    // so they fall back to zero every cycle rather than holding.
    always_comb begin
        state_d       = state_q;
        p_sel_d       = p_sel_q;
        p_enable_d    = p_enable_q;
        p_write_d     = p_write_q;
        p_addr_d      = p_addr_q;
        p_wdata_d     = p_wdata_q;
        p_strb_d      = p_strb_q;
        wait_cnt_d    = wait_cnt_q;
        err_count_d   = err_count_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = '0;
        rsp_err_d     = 1'b0;
        rsp_timeout_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    state_d    = SETUP;
                    p_sel_d    = 1'b1;
                    p_enable_d = 1'b0;
                    p_write_d  = bus.req_write;
                    p_addr_d   = bus.req_addr;
                    p_wdata_d  = bus.req_write ? bus.req_wdata : '0;
                    p_strb_d   = bus.req_write ? bus.req_strb : '0;
                end
            end
            SETUP: begin
                state_d    = ACCESS;
                p_enable_d = 1'b1;
                wait_cnt_d = '0;
            end
            ACCESS: begin
                // A ready slave on the last allowed wait cycle still completes normally.
                if (bus.P_ready) begin
                    state_d     = IDLE;
                    p_sel_d     = 1'b0;
                    p_enable_d  = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = bus.P_slverr;
                    rsp_rdata_d = p_write_q ? '0 : bus.P_rdata;
                end else if ((TIMEOUT > 0) && (wait_cnt_q == WAIT_LAST)) begin
                    state_d       = IDLE;
                    p_sel_d       = 1'b0;
                    p_enable_d    = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_WIDTH'(1);
                end
            end
            default: begin
                state_d    = IDLE;
                p_sel_d    = 1'b0;
                p_enable_d = 1'b0;
            end
        endcase

        if (rsp_valid_d && rsp_err_d && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    always_ff @(posedge P_clk or negedge P_reset_n) begin
        if (!P_reset_n) begin
            state_q       <= IDLE;
            p_sel_q       <= 1'b0;
            p_enable_q    <= 1'b0;
            p_write_q     <= 1'b0;
            p_addr_q      <= '0;
            p_wdata_q     <= '0;
            p_strb_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            err_count_q   <= 8'd0;
            wait_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            p_sel_q       <= p_sel_d;
            p_enable_q    <= p_enable_d;
            p_write_q     <= p_write_d;
            p_addr_q      <= p_addr_d;
            p_wdata_q     <= p_wdata_d;
            p_strb_q      <= p_strb_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            err_count_q   <= err_count_d;
            wait_cnt_q    <= wait_cnt_d;
        end
    end

    assign bus.req_ready   = (state_q == IDLE);
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_timeout = rsp_timeout_q;
    assign bus.P_sel       = p_sel_q;
    assign bus.P_enable    = p_enable_q;
    assign bus.P_write     = p_write_q;
    assign bus.P_addr      = p_addr_q;
    assign bus.P_wdata     = p_wdata_q;
    assign bus.P_strb      = p_strb_q;
    assign err_count       = err_count_q;
endmodule

// File: tb/tb_apb_master_gen.sv
// Randomised bench for apb_master_gen: each transfer's outcome and timing come
// from a transaction-level model (wait count vs. timeout), checked cycle by cycle.
module tb_apb_master_gen;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 4;

    logic       P_clk;
    logic       P_reset_n;
    logic [7:0] err_count;
    int         total;
    int         bad;
    int         model_err;

    apb_master_gen_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    apb_master_gen #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .P_clk     (P_clk),
        .P_reset_n (P_reset_n),
        .bus       (bus),
        .err_count (err_count)
    );

    initial begin
        P_clk = 1'b0;
        forever #5 P_clk = ~P_clk;
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_sel"}, bus.P_sel, 0);
        checkOutput({tag, "_enable"}, bus.P_enable, 0);
        checkOutput({tag, "_write"}, bus.P_write, 0);
        checkOutput({tag, "_addr"}, bus.P_addr, 0);
        checkOutput({tag, "_wdata"}, bus.P_wdata, 0);
        checkOutput({tag, "_strb"}, bus.P_strb, 0);
        checkOutput({tag, "_rsp_valid"}, bus.rsp_valid, 0);
        checkOutput({tag, "_rsp_rdata"}, bus.rsp_rdata, 0);
        checkOutput({tag, "_rsp_err"}, bus.rsp_err, 0);
        checkOutput({tag, "_rsp_timeout"}, bus.rsp_timeout, 0);
        checkOutput({tag, "_err_count"}, err_count, 0);
        checkOutput({tag, "_req_ready"}, bus.req_ready, 1);
    endtask

    // Called at a falling edge with the master idle; returns at the falling
    // edge of the response cycle, so calls chain back-to-back.
    task automatic applyStimulus(input logic wr, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] wdata, input logic [SW-1:0] strb,
                                 input int waits, input logic [DW-1:0] rdata,
                                 input logic slverr);
        logic [DW-1:0] exp_wdata;
        logic [SW-1:0] exp_strb;
        logic          timed_out;
        int            access_cycles;

        exp_wdata     = wr ? wdata : '0;
        exp_strb      = wr ? strb : '0;
        timed_out     = (TO > 0) && (waits >= TO);
        access_cycles = timed_out ? TO : waits + 1;

        checkOutput("idle_req_ready", bus.req_ready, 1);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_strb  = strb;

        @(negedge P_clk);
        bus.req_valid = 1'b0;
        bus.req_write = 1'($urandom);
        bus.req_addr  = AW'($urandom);
        bus.req_wdata = DW'($urandom);
        bus.req_strb  = SW'($urandom);
        bus.P_ready   = 1'($urandom);
        bus.P_slverr  = 1'($urandom);
        bus.P_rdata   = DW'($urandom);
        checkOutput("setup_sel", bus.P_sel, 1);
        checkOutput("setup_enable", bus.P_enable, 0);
        checkOutput("setup_req_ready", bus.req_ready, 0);
        checkOutput("setup_rsp_valid", bus.rsp_valid, 0);
        checkOutput("setup_write", bus.P_write, wr);
        checkOutput("setup_addr", bus.P_addr, addr);
        checkOutput("setup_wdata", bus.P_wdata, exp_wdata);
        checkOutput("setup_strb", bus.P_strb, exp_strb);

        for (int c = 0; c < access_cycles; c++) begin
            @(negedge P_clk);
            checkOutput("access_sel", bus.P_sel, 1);
            checkOutput("access_enable", bus.P_enable, 1);
            checkOutput("access_req_ready", bus.req_ready, 0);
            checkOutput("access_rsp_valid", bus.rsp_valid, 0);
            checkOutput("access_write", bus.P_write, wr);
            checkOutput("access_addr", bus.P_addr, addr);
            checkOutput("access_wdata", bus.P_wdata, exp_wdata);
            checkOutput("access_strb", bus.P_strb, exp_strb);
            if (!timed_out && c == waits) begin
                bus.P_ready  = 1'b1;
                bus.P_rdata  = rdata;
                bus.P_slverr = slverr;
            end else begin
                bus.P_ready  = 1'b0;
                bus.P_rdata  = DW'($urandom);
                bus.P_slverr = 1'($urandom);
            end
        end

        @(negedge P_clk);
        bus.P_ready  = 1'($urandom);
        bus.P_slverr = 1'($urandom);
        if ((timed_out || slverr) && model_err < 255) model_err++;
        checkOutput("rsp_valid", bus.rsp_valid, 1);
        checkOutput("rsp_err", bus.rsp_err, timed_out ? 1'b1 : slverr);
        checkOutput("rsp_timeout", bus.rsp_timeout, timed_out);
        checkOutput("rsp_rdata", bus.rsp_rdata, (timed_out || wr) ? '0 : rdata);
        checkOutput("rsp_sel", bus.P_sel, 0);
        checkOutput("rsp_enable", bus.P_enable, 0);
        checkOutput("rsp_req_ready", bus.req_ready, 1);
        checkOutput("err_count", err_count, model_err);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge P_clk);
            checkOutput("gap_rsp_valid", bus.rsp_valid, 0);
            checkOutput("gap_sel", bus.P_sel, 0);
        end
    endtask

    initial begin
        int acc_cyc[3];
        int accepted;
        int rsp_cnt;
        int sel_low;

        total         = 0;
        bad           = 0;
        model_err     = 0;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_strb  = '0;
        bus.P_rdata   = '0;
        bus.P_ready   = 1'b0;
        bus.P_slverr  = 1'b0;
        P_reset_n     = 1'b1;
        #1 P_reset_n  = 1'b0;

        repeat (3) @(negedge P_clk);
        checkAllZero("por");
        P_reset_n = 1'b1;
        @(negedge P_clk);

        // Leave a nonzero error count and a live transfer, then reset mid-ACCESS.
        applyStimulus(1'b1, 8'h10, 32'hCAFE0001, 4'hF, 0, '0, 1'b1);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 8'h55;
        bus.req_wdata = 32'hA5A5A5A5;
        bus.req_strb  = 4'h3;
        @(negedge P_clk);
        bus.req_valid = 1'b0;
        bus.P_ready   = 1'b0;
        repeat (2) @(negedge P_clk);
        checkOutput("pre_reset_enable", bus.P_enable, 1);
        #2 P_reset_n = 1'b0;
        #1 checkAllZero("async_reset");
        model_err = 0;
        @(negedge P_clk);
        P_reset_n   = 1'b1;
        bus.P_ready = 1'b1;
        idleCycles(5);

        applyStimulus(1'b1, 8'h3C, 32'hDEADBEEF, 4'hF, 0, '0, 1'b0);
        applyStimulus(1'b0, 8'hA5, 32'h0, 4'h0, 3, 32'h12345678, 1'b0);
        idleCycles(1);
        checkOutput("err_before_slverr", err_count, 0);
        applyStimulus(1'b1, 8'h20, 32'h01020304, 4'h5, 1, '0, 1'b1);
        applyStimulus(1'b0, 8'h44, 32'h0, 4'h0, TO, 32'hFFFFFFFF, 1'b0);
        applyStimulus(1'b0, 8'h48, 32'h0, 4'h0, TO - 1, 32'h0BADF00D, 1'b1);

        for (int n = 0; n < 60; n++) begin
            applyStimulus(1'($urandom), AW'($urandom), DW'($urandom), SW'($urandom),
                          int'($urandom_range(0, TO + 2)), DW'($urandom), 1'($urandom));
            if ($urandom_range(0, 2) == 0) idleCycles(int'($urandom_range(1, 3)));
        end

        for (int n = 0; n < 300; n++) begin
            applyStimulus(1'($urandom), AW'($urandom), DW'($urandom), SW'($urandom),
                          TO + int'($urandom_range(0, 3)), DW'($urandom), 1'b0);
        end
        checkOutput("err_saturated", err_count, 255);

        idleCycles(1);
        bus.P_ready   = 1'b1;
        bus.P_slverr  = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 8'h77;
        bus.req_wdata = 32'h11223344;
        bus.req_strb  = 4'hF;
        accepted      = 0;
        rsp_cnt       = 0;
        sel_low       = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (cyc > 0) @(negedge P_clk);
            if (bus.rsp_valid) rsp_cnt++;
            if (accepted >= 1 && rsp_cnt < 3 && !bus.P_sel) sel_low++;
            if (accepted < 3 && bus.req_valid && bus.req_ready) begin
                acc_cyc[accepted] = cyc;
                accepted++;
            end else if (accepted == 3) begin
                bus.req_valid = 1'b0;
            end
        end
        checkOutput("b2b_accepted", accepted, 3);
        checkOutput("b2b_gap01", acc_cyc[1] - acc_cyc[0], 3);
        checkOutput("b2b_gap12", acc_cyc[2] - acc_cyc[1], 3);
        checkOutput("b2b_rsp_count", rsp_cnt, 3);
        checkOutput("b2b_sel_low", sel_low, 2);
        checkOutput("b2b_err_count", err_count, 255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
